// File: rtl/ram_dp_hs_pkg.sv
// ram_dp_hs shared constants and sizing helpers.
// Optional collision counter: RAM_DP_HS_COLLISION_CNT_EN.
package ram_dp_hs_pkg;

  localparam int COLL_CNT_W = 16;

  function automatic int calc_latency(input int out_reg);
    return 1 + out_reg;
  endfunction

  function automatic int calc_resp_depth(input int out_reg);
    return calc_latency(out_reg) + 1;
  endfunction

  function automatic int credit_width(input int resp_depth);
    return $clog2(resp_depth + 1);
  endfunction

endpackage

// File: rtl/ram_dp_hs_resp_fifo.sv
// Fall-through response FIFO; an empty FIFO passes the
// pipeline output straight to the consumer.
module ram_dp_hs_resp_fifo
  import ram_dp_hs_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  output logic [DW-1:0] out_data,
  input  logic          out_rdy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] buf_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          empty;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty    = (cnt == '0);
  assign push     = in_vld && !(empty && out_rdy);
  assign pop      = !empty && out_rdy;
  assign out_vld  = !empty || in_vld;
  assign out_data = !empty ? buf_q[rd_ptr]
                  : (in_vld ? in_data : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/ram_dp_hs.sv
// True dual-port RAM with valid/ready request and response channels.
// Define RAM_DP_HS_COLLISION_CNT_EN to add the collision_cnt output.
module ram_dp_hs
  import ram_dp_hs_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int OUT_REG    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_req_vld,
  output logic                    a_req_rdy,
  input  logic                    a_req_we,
  input  logic [ADDR_WIDTH-1:0]   a_req_addr,
  input  logic [DATA_WIDTH/8-1:0] a_req_be,
  input  logic [DATA_WIDTH-1:0]   a_req_din,
  output logic                    a_resp_vld,
  input  logic                    a_resp_rdy,
  output logic [DATA_WIDTH-1:0]   a_resp_dout,
  input  logic                    b_req_vld,
  output logic                    b_req_rdy,
  input  logic                    b_req_we,
  input  logic [ADDR_WIDTH-1:0]   b_req_addr,
  input  logic [DATA_WIDTH/8-1:0] b_req_be,
  input  logic [DATA_WIDTH-1:0]   b_req_din,
  output logic                    b_resp_vld,
  input  logic                    b_resp_rdy,
  output logic [DATA_WIDTH-1:0]   b_resp_dout
`ifdef RAM_DP_HS_COLLISION_CNT_EN
  ,
  output logic [COLL_CNT_W-1:0]   collision_cnt
`endif
);

  localparam int BE_WIDTH   = DATA_WIDTH / 8;
  localparam int LATENCY    = calc_latency(OUT_REG);
  localparam int RESP_DEPTH = calc_resp_depth(OUT_REG);
  localparam int CW         = credit_width(RESP_DEPTH);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic [1:0]                 vld;
  logic [1:0]                 we;
  logic [1:0]                 rdy;
  logic [1:0]                 acc;
  logic [1:0]                 rd_acc;
  logic [1:0]                 wr_acc;
  logic [1:0]                 hs;
  logic [1:0]                 rvld;
  logic [1:0]                 rrdy;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][BE_WIDTH-1:0]   be;
  logic [1:0][DATA_WIDTH-1:0] din;
  logic [1:0][DATA_WIDTH-1:0] dout;
  logic                       rst_done;
  logic                       a_hit;

  assign vld  = {b_req_vld, a_req_vld};
  assign we   = {b_req_we, a_req_we};
  assign addr = {b_req_addr, a_req_addr};
  assign be   = {b_req_be, a_req_be};
  assign din  = {b_req_din, a_req_din};
  assign rrdy = {b_resp_rdy, a_resp_rdy};

  assign a_req_rdy   = rdy[0];
  assign b_req_rdy   = rdy[1];
  assign a_resp_vld  = rvld[0];
  assign b_resp_vld  = rvld[1];
  assign a_resp_dout = dout[0];
  assign b_resp_dout = dout[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  // Port a owns every byte it enables on a shared address.
  assign a_hit = wr_acc[0] && (addr[0] == addr[1]);

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (wr_acc[0] && be[0][i])
        mem[addr[0]][i*8 +: 8] <= din[0][i*8 +: 8];
      if (wr_acc[1] && be[1][i] && !(a_hit && be[0][i]))
        mem[addr[1]][i*8 +: 8] <= din[1][i*8 +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [CW-1:0]         credit;
    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  pipe_vld;
    logic [DATA_WIDTH-1:0] pipe_data;

    assign rdy[p]    = rst_done &&
                       ((credit < CW'(RESP_DEPTH)) || we[p]);
    assign acc[p]    = vld[p] && rdy[p];
    assign rd_acc[p] = acc[p] && !we[p];
    assign wr_acc[p] = acc[p] && we[p];
    assign hs[p]     = rvld[p] && rrdy[p];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        credit <= '0;
      end else if (rd_acc[p] && !hs[p]) begin
        credit <= credit + 1'b1;
      end else if (!rd_acc[p] && hs[p]) begin
        credit <= credit - 1'b1;
      end
    end

    // Array sampled at the accept edge: a same-edge write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_vld  <= 1'b0;
        s1_data <= '0;
      end else begin
        s1_vld <= rd_acc[p];
        if (rd_acc[p]) s1_data <= mem[addr[p]];
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic                  s2_vld;
      logic [DATA_WIDTH-1:0] s2_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vld  <= 1'b0;
          s2_data <= '0;
        end else begin
          s2_vld  <= s1_vld;
          s2_data <= s1_data;
        end
      end

      assign pipe_vld  = s2_vld;
      assign pipe_data = s2_data;
    end else begin : g_noreg
      assign pipe_vld  = s1_vld;
      assign pipe_data = s1_data;
    end

    ram_dp_hs_resp_fifo #(
      .DW    (DATA_WIDTH),
      .DEPTH (RESP_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (pipe_vld),
      .in_data  (pipe_data),
      .out_vld  (rvld[p]),
      .out_data (dout[p]),
      .out_rdy  (rrdy[p])
    );
  end

`ifdef RAM_DP_HS_COLLISION_CNT_EN
  logic coll;

  assign coll = acc[0] && acc[1] &&
                (addr[0] == addr[1]) && (we[0] || we[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_cnt <= '0;
    end else if (coll && (collision_cnt != '1)) begin
      collision_cnt <= collision_cnt + 1'b1;
    end
  end
`endif

endmodule
